// File: rtl/tia_hsync_counter_pkg.sv
// Shared definitions for the TIA horizontal and vertical polynomial counters:
// counter width, line length, LFSR step function and decoded step patterns.
package tia_hsync_counter_pkg;

    localparam int unsigned H_WIDTH      = 6;
    localparam int unsigned H_LINE_STEPS = 57;

    typedef logic [H_WIDTH-1:0] hcount_t;

    // One strobe per decoded counter state; at most one is ever set.
    typedef struct packed {
        logic hend;
        logic cnt;
        logic lrhb;
        logic rhb;
        logic rcb;
        logic rhs;
        logic shs;
        logic shb;
    } strobe_t;

    // Shift left, feeding back the XNOR of the two top bits. Seeded with
    // all-zeros this never reaches the all-ones lockup state.
    function automatic hcount_t lfsr_next(input hcount_t cur);
        return {cur[H_WIDTH-2:0], ~(cur[H_WIDTH-1] ^ cur[H_WIDTH-2])};
    endfunction

    // Counter pattern reached after 'step' advances from all-zeros.
    // Only ever evaluated at elaboration to build the decode constants.
    function automatic hcount_t lfsr_at(input int unsigned step);
        hcount_t v;
        v = '0;
        for (int unsigned i = 0; i < step; i++) begin
            v = lfsr_next(v);
        end
        return v;
    endfunction

    localparam hcount_t PAT_SHB  = lfsr_at(0);
    localparam hcount_t PAT_SHS  = lfsr_at(4);
    localparam hcount_t PAT_RHS  = lfsr_at(8);
    localparam hcount_t PAT_RCB  = lfsr_at(12);
    localparam hcount_t PAT_RHB  = lfsr_at(16);
    localparam hcount_t PAT_LRHB = lfsr_at(18);
    localparam hcount_t PAT_CNT  = lfsr_at(36);

endpackage

// File: rtl/tia_phase_gen.sv
// Divide-by-4 phase generator: free-running 2-bit phase counter, two
// non-overlapping registered phase clocks and the counter advance enable.
module tia_phase_gen (
    input  logic clk,
    input  logic reset_n,
    output logic hphi1,
    output logic hphi2,
    output logic advance
);

    logic [1:0] ph;

    // Phase counter; the phase clocks decode the value ph is about to take,
    // so once registered they line up with ph==0 and ph==2 respectively.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph    <= '0;
            hphi1 <= 1'b1;
            hphi2 <= 1'b0;
        end else begin
            ph    <= ph + 2'd1;
            hphi1 <= (ph == 2'd3);
            hphi2 <= (ph == 2'd1);
        end
    end

    assign advance = (ph == 2'd3);

endmodule

// File: rtl/tia_hsync_counter.sv
// TIA horizontal sync counter: 6-bit polynomial counter stepped once per four
// colour clocks, RSYNC-driven early wrap and decode of the fixed line states.
module tia_hsync_counter
    import tia_hsync_counter_pkg::*;
#(
    parameter int unsigned LINE_STEPS = H_LINE_STEPS,
    parameter int unsigned WIDTH      = H_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rsync,
    output logic             hphi1,
    output logic             hphi2,
    output logic [WIDTH-1:0] hcount,
    output logic             shb,
    output logic             shs,
    output logic             rhs,
    output logic             rcb,
    output logic             rhb,
    output logic             lrhb,
    output logic             cnt,
    output logic             hend,
    output logic             line_start
);

    localparam hcount_t PAT_END = lfsr_at(LINE_STEPS - 1);

    logic    advance;
    logic    wrap;
    logic    rsync_pend;
    hcount_t lfsr;
    strobe_t strobes;

    tia_phase_gen u_phase (
        .clk     (clk),
        .reset_n (reset_n),
        .hphi1   (hphi1),
        .hphi2   (hphi2),
        .advance (advance)
    );

    // A same-edge rsync is folded in directly so it wraps without waiting a
    // further four clocks; a pending request plus END still gives one wrap.
    assign wrap = (lfsr == PAT_END) || rsync_pend || rsync;

    // Counter step or wrap on the advance edge; rsync is remembered until then.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr       <= '0;
            rsync_pend <= 1'b0;
            line_start <= 1'b0;
        end else begin
            line_start <= advance && wrap;
            if (advance) begin
                lfsr       <= wrap ? '0 : lfsr_next(lfsr);
                rsync_pend <= 1'b0;
            end else if (rsync) begin
                rsync_pend <= 1'b1;
            end
        end
    end

    // Decode of the registered counter; stable for the whole four-clock step.
    always_comb begin
        strobes      = '0;
        strobes.shb  = (lfsr == PAT_SHB);
        strobes.shs  = (lfsr == PAT_SHS);
        strobes.rhs  = (lfsr == PAT_RHS);
        strobes.rcb  = (lfsr == PAT_RCB);
        strobes.rhb  = (lfsr == PAT_RHB);
        strobes.lrhb = (lfsr == PAT_LRHB);
        strobes.cnt  = (lfsr == PAT_CNT);
        strobes.hend = (lfsr == PAT_END);
    end

    assign hcount = lfsr;
    assign shb    = strobes.shb;
    assign shs    = strobes.shs;
    assign rhs    = strobes.rhs;
    assign rcb    = strobes.rcb;
    assign rhb    = strobes.rhb;
    assign lrhb   = strobes.lrhb;
    assign cnt    = strobes.cnt;
    assign hend   = strobes.hend;

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Self-checking bench for tia_hsync_counter: per-cycle scoreboard against a
// step-index model, a table of post-reset vectors and rsync/reset sequences.
`timescale 1ns/1ps
module tb_tia_hsync_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rsync = 1'b0;
    logic       hphi1, hphi2;
    logic [5:0] hcount;
    logic       shb, shs, rhs, rcb, rhb, lrhb, cnt, hend, line_start;

    always #5 clk = ~clk;

    tia_hsync_counter #(.LINE_STEPS(57), .WIDTH(6)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rsync      (rsync),
        .hphi1      (hphi1),
        .hphi2      (hphi2),
        .hcount     (hcount),
        .shb        (shb),
        .shs        (shs),
        .rhs        (rhs),
        .rcb        (rcb),
        .rhb        (rhb),
        .lrhb       (lrhb),
        .cnt        (cnt),
        .hend       (hend),
        .line_start (line_start)
    );

    typedef struct packed {
        logic [5:0] hc;
        logic [7:0] stb;   // {hend,cnt,lrhb,rhb,rcb,rhs,shs,shb}
        logic       h1;
        logic       h2;
        logic       ls;
    } obs_t;

    typedef struct {
        int unsigned n;
        logic        chk_hc;
        obs_t        exp;
    } vec_t;

    logic [7:0] stb_bus;
    obs_t       act;
    assign stb_bus = {hend, cnt, lrhb, rhb, rcb, rhs, shs, shb};
    assign act     = {hcount, stb_bus, hphi1, hphi2, line_start};

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned base = 0;
    int unsigned ls_count = 0;
    int unsigned last_ls = 0;
    int unsigned prev_ls = 0;

    obs_t        exp_q[$];
    vec_t        vecs[$];
    logic [5:0]  ref_pat[57];

    int unsigned m_step = 0;
    int unsigned m_ph = 0;
    logic        m_pend = 1'b0;
    logic        m_ls = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, actual, required, cyc);
        end
    endtask

    function automatic logic [7:0] stb_of(input int unsigned s);
        logic [7:0] b;
        b = '0;
        b[0] = (s == 0);
        b[1] = (s == 4);
        b[2] = (s == 8);
        b[3] = (s == 12);
        b[4] = (s == 16);
        b[5] = (s == 18);
        b[6] = (s == 36);
        b[7] = (s == 56);
        return b;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.hc  = ref_pat[m_step];
        o.stb = stb_of(m_step);
        o.h1  = (m_ph == 0);
        o.h2  = (m_ph == 2);
        o.ls  = m_ls;
        return o;
    endfunction

    // One colour clock: model update at the edge, compare at the falling edge,
    // return 1 ns later so stimulus changes land well away from both edges.
    task automatic tick();
        obs_t e;
        logic adv, wrap;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            m_step = 0; m_ph = 0; m_pend = 1'b0; m_ls = 1'b0;
        end else begin
            adv  = (m_ph == 3);
            wrap = adv && (m_step == 56 || m_pend || rsync);
            m_ls = wrap;
            if (adv) begin
                m_step = wrap ? 0 : m_step + 1;
                m_pend = 1'b0;
            end else if (rsync) begin
                m_pend = 1'b1;
            end
            m_ph = (m_ph + 1) % 4;
        end
        exp_q.push_back(model_obs());
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", 32'(act), 32'(e));
            check("no_x", 32'($isunknown(act)), 32'd0);
            check("phase_onehot", 32'((hphi1 && hphi2) || ($countones(stb_bus) > 1)), 32'd0);
        end
        if (line_start) begin
            ls_count++;
            prev_ls = last_ls;
            last_ls = cyc;
        end
        #1;
    endtask

    task automatic run_to(input int unsigned target);
        while (cyc - base < target) tick();
    endtask

    task automatic wait_ls(input int unsigned bound);
        int unsigned start;
        start = ls_count;
        for (int unsigned i = 0; i < bound && ls_count == start; i++) tick();
        check("wait_line_start", 32'(ls_count != start), 32'd1);
    endtask

    task automatic add_vec(input int unsigned n, input logic chk, input logic [5:0] hc,
                           input logic [7:0] stb, input logic h1, input logic h2, input logic ls);
        vec_t v;
        v.n = n;
        v.chk_hc = chk;
        v.exp = {hc, stb, h1, h2, ls};
        vecs.push_back(v);
    endtask

    initial begin
        int unsigned ls_before;
        obs_t o;

        ref_pat[0] = '0;
        for (int i = 1; i < 57; i++)
            ref_pat[i] = {ref_pat[i-1][4:0], ~(ref_pat[i-1][5] ^ ref_pat[i-1][4])};

        add_vec(0,   1, 6'b000000, 8'b00000001, 1, 0, 0);
        add_vec(1,   1, 6'b000000, 8'b00000001, 0, 0, 0);
        add_vec(2,   1, 6'b000000, 8'b00000001, 0, 1, 0);
        add_vec(3,   1, 6'b000000, 8'b00000001, 0, 0, 0);
        add_vec(4,   1, 6'b000001, 8'b00000000, 1, 0, 0);
        add_vec(8,   1, 6'b000011, 8'b00000000, 1, 0, 0);
        add_vec(12,  1, 6'b000111, 8'b00000000, 1, 0, 0);
        add_vec(16,  1, 6'b001111, 8'b00000010, 1, 0, 0);
        add_vec(19,  1, 6'b001111, 8'b00000010, 0, 0, 0);
        add_vec(20,  1, 6'b011111, 8'b00000000, 1, 0, 0);
        add_vec(32,  1, 6'b111011, 8'b00000100, 1, 0, 0);
        add_vec(48,  1, 6'b111100, 8'b00001000, 1, 0, 0);
        add_vec(64,  0, 6'b000000, 8'b00010000, 1, 0, 0);
        add_vec(72,  0, 6'b000000, 8'b00100000, 1, 0, 0);
        add_vec(144, 0, 6'b000000, 8'b01000000, 1, 0, 0);
        add_vec(224, 0, 6'b000000, 8'b10000000, 1, 0, 0);
        add_vec(227, 0, 6'b000000, 8'b10000000, 0, 0, 0);
        add_vec(228, 1, 6'b000000, 8'b00000001, 1, 0, 1);
        add_vec(229, 1, 6'b000000, 8'b00000001, 0, 0, 0);
        add_vec(232, 1, 6'b000001, 8'b00000000, 1, 0, 0);

        // Initial reset, then free run against the table.
        repeat (3) tick();
        reset_n = 1'b1;
        base = cyc;
        for (int unsigned i = 0; i < vecs.size(); i++) begin
            run_to(vecs[i].n);
            o = act;
            if (!vecs[i].chk_hc) o.hc = vecs[i].exp.hc;
            check($sformatf("vec_n%0d", vecs[i].n), 32'(o), 32'(vecs[i].exp));
        end

        // rsync at step 30, ph==1 of line 2: wrap two clocks later.
        run_to(349);
        rsync = 1'b1;
        ls_before = ls_count;
        tick();
        rsync = 1'b0;
        tick();
        check("rsync_no_early_wrap", 32'(line_start), 32'd0);
        tick();
        check("rsync_line_start", 32'(line_start), 32'd1);
        for (int unsigned i = 0; i < 4; i++) begin
            check("rsync_shb_held", 32'(shb), 32'd1);
            tick();
        end
        check("rsync_step1", 32'(hcount), 32'h01);
        check("rsync_one_pulse", ls_count - ls_before, 32'd1);

        // rsync on the ph==3 edge at step 56: single wrap, normal next period.
        run_to(579);
        check("end_before_rsync", 32'(hend), 32'd1);
        rsync = 1'b1;
        ls_before = ls_count;
        tick();
        rsync = 1'b0;
        check("end_rsync_line_start", 32'(line_start), 32'd1);
        wait_ls(300);
        check("end_rsync_one_wrap", ls_count - ls_before, 32'd2);
        check("end_rsync_period", last_ls - prev_ls, 32'd228);

        // rsync held for three clocks while pending: absorbed into one wrap.
        run_to(848);
        rsync = 1'b1;
        ls_before = ls_count;
        repeat (3) tick();
        rsync = 1'b0;
        repeat (6) tick();
        check("absorb_one_wrap", ls_count - ls_before, 32'd1);
        check("absorb_wrap_cycle", last_ls - base, 32'd852);
        wait_ls(300);
        check("absorb_next_period", last_ls - prev_ls, 32'd228);

        // Reset mid-line at step 20: immediate return to reset values.
        run_to(1161);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(act), 32'({6'b000000, 8'b00000001, 1'b1, 1'b0, 1'b0}));
        repeat (3) tick();
        reset_n = 1'b1;
        base = cyc;
        for (int unsigned i = 0; i < 4; i++) begin
            run_to(i);
            check("post_reset_shb", 32'(shb), 32'd1);
        end
        run_to(4);
        check("post_reset_step1", 32'(hcount), 32'h01);

        // Long free run under the scoreboard, then period check.
        repeat (100 * 228) tick();
        check("free_run_period", last_ls - prev_ls, 32'd228);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
